// File: rtl/inst_mem_sync_pkg.sv
// Shared definitions for the synchronous instruction memory: FSM encodings,
// the MIPS NOP word and the fetch-address fault check.
package inst_mem_sync_pkg;

  // FSM encodings kept as plain 2-bit constants for legacy tool flows.
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // A fetch faults when the byte address is not word aligned, or when it
  // points past the last implemented word (any bit above the index is set).
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input int unsigned addr_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (addr_w + 2)) != 32'd0);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/inst_mem_sync_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read
// port with read enable. The read register holds its value while re=0,
// which the top level relies on for its output hold behaviour.
module imem_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: no reset on the array; contents are swept by the owner.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered data, updated only when a read is issued.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the IF stage. After reset it sweeps
// every word to NOP, then serves registered fetches with one-cycle latency.
// A sequential load port (re)writes the program between fetch phases.
import inst_mem_sync_pkg::*;

module inst_mem_sync #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid,
  output logic              fetch_fault,
  output logic              ready,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ptr;

  logic              accept;
  logic              fault;
  logic [ADDR_W-1:0] fetch_idx;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Selects NOP_WORD instead of the RAM read register. Set by reset and by
  // faulting fetches so inst_o never exposes stale or unread RAM data.
  logic              nop_sel;

  assign ready     = (state == ST_RUN);
  assign fault     = addr_fault(fetch_addr, ADDR_W);
  assign fetch_idx = fetch_addr[ADDR_W+1:2];

  // A same-cycle ld_start wins over the fetch: the fetch is dropped.
  assign accept    = ready & fetch_req & ~stall & ~ld_start;

  // Faulting fetches never touch the array; the output is forced to NOP.
  assign ram_re    = accept & ~fault;

  // Write mux: CLEAR sweep writes NOP at clr_ptr, LOAD writes ld_data at ptr.
  // A reloading ld_start in LOAD suppresses a coincident ld_valid write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr;
    ram_wdata = ld_data;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = NOP_WORD;
      end
      ST_LOAD: ram_we = ld_valid & ~ld_start;
      default: ;
    endcase
  end

  // Control FSM with clear sweep and load write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) state <= ST_RUN;
        end
        ST_RUN: begin
          if (ld_start) begin
            state <= ST_LOAD;
            ptr   <= ld_base;
          end
        end
        ST_LOAD: begin
          if (ld_start)      ptr <= ld_base;
          else if (ld_valid) ptr <= ptr + 1'b1;
          if (ld_done) state <= ST_RUN;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Response flags: everything holds under stall; otherwise valid follows
  // accept, and fault/NOP-select track the most recent accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      nop_sel     <= 1'b1;
    end else if (!stall) begin
      inst_valid <= accept;
      if (accept) begin
        fetch_fault <= fault;
        nop_sel     <= fault;
      end
    end
  end

  assign inst_o = nop_sel ? NOP_WORD : ram_rdata;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: directed scenarios followed by a
// randomized fetch/load/stall mix, all compared against a word-array model.
module tb_inst_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        stall;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        fetch_fault;
  logic        ready;
  logic        ld_start;
  logic [5:0]  ld_base;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents, mode and expected outputs.
  logic [31:0] mm [64];
  int          m_mode;     // 0 = sweeping, 1 = running, 2 = loading
  int          m_clr;      // sweep cycles remaining
  int          m_ptr;
  logic [31:0] exp_inst;
  logic        exp_valid;
  logic        exp_fault;

  inst_mem_sync #(.DATA_W(32), .ADDR_W(6), .NOP_WORD(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .stall      (stall),
    .inst_o     (inst_o),
    .inst_valid (inst_valid),
    .fetch_fault(fetch_fault),
    .ready      (ready),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_done    (ld_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mm[i] = 32'h0;
    m_mode    = 0;
    m_clr     = 64;
    m_ptr     = 0;
    exp_inst  = 32'h0;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
  endtask

  // One clock: drive at the falling edge, update the model, clock, then
  // compare all outputs at the next falling edge.
  task automatic cyc(input logic fr, input logic [31:0] fa, input logic st,
                     input logic ls, input logic [5:0] lb, input logic lv,
                     input logic [31:0] ld, input logic dn);
    logic acc, flt;
    fetch_req = fr; fetch_addr = fa; stall = st;
    ld_start = ls; ld_base = lb; ld_valid = lv; ld_data = ld; ld_done = dn;

    acc = (m_mode == 1) && fr && !st && !ls;
    flt = (fa % 4 != 0) || (fa >= 32'd256);
    if (!st) begin
      exp_valid = acc;
      if (acc) begin
        exp_fault = flt;
        exp_inst  = flt ? 32'h0 : mm[fa / 4];
      end
    end
    case (m_mode)
      0: begin
        m_clr--;
        if (m_clr == 0) m_mode = 1;
      end
      1: if (ls) begin m_mode = 2; m_ptr = lb; end
      default: begin
        if (ls) m_ptr = lb;
        else if (lv) begin mm[m_ptr] = ld; m_ptr = (m_ptr + 1) % 64; end
        if (dn) m_mode = 1;
      end
    endcase

    @(posedge clk);
    @(negedge clk);
    check("ready",       {31'b0, ready},       {31'b0, m_mode == 1});
    check("inst_valid",  {31'b0, inst_valid},  {31'b0, exp_valid});
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    check("inst_o",      inst_o,               exp_inst);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    cyc(1, a, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    logic [31:0] wa, wb, ra;
    logic [5:0]  rb;

    // ---- 1: reset values, 64-cycle sweep, first fetch ----
    rst_n = 1'b0;
    fetch_req = 0; fetch_addr = 0; stall = 0;
    ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0; ld_done = 0;
    model_reset();
    #3;
    check("rst_inst",  inst_o, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!ready && cnt < 200) begin idle(); cnt++; end
    check("clear_cycles", cnt, 64);
    fetch(32'h10);
    check("t1_inst",  inst_o, 32'h0);
    check("t1_valid", {31'b0, inst_valid}, 32'h1);

    // ---- 2: load three words, fetch back-to-back ----
    cyc(0, 0, 0, 1, 6'd0, 0, 0, 0);
    check("t2_ready_load", {31'b0, ready}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h14000401, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h14000802, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h14001003, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("t2_ready_run", {31'b0, ready}, 32'h1);
    fetch(32'h0); check("t2_w0", inst_o, 32'h14000401);
    fetch(32'h4); check("t2_w1", inst_o, 32'h14000802);
    fetch(32'h8); check("t2_w2", inst_o, 32'h14001003);

    // ---- 3: stall hold ----
    fetch(32'h4); check("t3_resp", inst_o, 32'h14000802);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h8, 1, 0, 0, 0, 0, 0);
      check("t3_hold_inst",  inst_o, 32'h14000802);
      check("t3_hold_valid", {31'b0, inst_valid}, 32'h1);
    end
    idle();
    check("t3_after_inst",  inst_o, 32'h14000802);
    check("t3_after_valid", {31'b0, inst_valid}, 32'h0);

    // ---- 4: faults ----
    fetch(32'h6);
    check("t4_mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("t4_mis_inst",  inst_o, 32'h0);
    fetch(32'h100);
    check("t4_oor_fault", {31'b0, fetch_fault}, 32'h1);
    check("t4_oor_inst",  inst_o, 32'h0);
    fetch(32'h8);
    check("t4_good_fault", {31'b0, fetch_fault}, 32'h0);
    check("t4_good_inst",  inst_o, 32'h14001003);

    // ---- 5: pointer wrap, fetch dropped by ld_start ----
    wa = 32'hA5A5_0001; wb = 32'hB6B6_0002;
    cyc(1, 32'h0, 0, 1, 6'd63, 0, 0, 0);
    check("t5_drop_valid", {31'b0, inst_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, wa, 0);
    cyc(0, 0, 0, 0, 0, 1, wb, 1);
    fetch(32'hFC); check("t5_mem63", inst_o, wa);
    fetch(32'h0);  check("t5_mem0",  inst_o, wb);
    fetch(32'h4);  check("t5_mem1",  inst_o, 32'h14000802);

    // ---- 6: async reset mid-load, sweep discards it ----
    fetch(32'hFC);
    cyc(0, 0, 0, 1, 6'd5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_inst",  inst_o, 32'h0);
    check("t6_async_valid", {31'b0, inst_valid}, 32'h0);
    check("t6_async_fault", {31'b0, fetch_fault}, 32'h0);
    check("t6_async_ready", {31'b0, ready}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!ready && cnt < 200) begin
      // load-port and fetch noise during the sweep must be ignored
      cyc($urandom_range(0, 1), $urandom, 0, $urandom_range(0, 1),
          6'($urandom), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      cnt++;
    end
    check("t6_clear_cycles", cnt, 64);
    fetch(32'h0);  check("t6_mem0", inst_o, 32'h0);
    fetch(32'h14); check("t6_mem5", inst_o, 32'h0);

    // ---- random mix against the model ----
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) != 0) ra = {24'h0, 6'($urandom), 2'b00};
      else if ($urandom_range(0, 1) != 0) ra = {24'h0, 8'($urandom)};
      else ra = $urandom;
      rb = 6'($urandom);
      if (m_mode == 1)
        cyc($urandom_range(0, 3) != 0, ra, $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0, rb, $urandom_range(0, 1),
            $urandom, $urandom_range(0, 1));
      else
        cyc($urandom_range(0, 1), ra, $urandom_range(0, 5) == 0,
            $urandom_range(0, 29) == 0, rb, $urandom_range(0, 1),
            $urandom, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
